// File: rtl/rr_grant_sched_if.sv
// Request/grant bundle between the requesters and the round-robin scheduler.
// The master side drives requests and the release strobe; the slave side is the scheduler.
interface rr_grant_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [IW-1:0]      gnt_idx_o;
    logic               gnt_valid_o;
    logic [NUM_REQ-1:0] gnt_o;
    logic               timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  gnt_idx_o,
        input  gnt_valid_o,
        input  gnt_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output gnt_idx_o,
        output gnt_valid_o,
        output gnt_o,
        output timeout_o
    );
endinterface

// File: rtl/rr_grant_sched.sv
// Round-robin scheduler for one shared resource: registered binary grant plus one-hot
// decode, held until the owner releases or the hold watchdog fires, then priority rotates.
module rr_grant_sched #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    rr_grant_sched_if.slave   bus
);
    localparam int          IW        = $clog2(NUM_REQ);
    localparam logic        WDOG_EN   = (MAX_HOLD != 0) ? 1'b1 : 1'b0;
    localparam logic [15:0] HOLD_LAST = (MAX_HOLD != 0) ? 16'(MAX_HOLD - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_r,     state_s;
    logic [IW-1:0]      ptr_r,       ptr_s;
    logic [15:0]        hold_r,      hold_s;
    logic [IW-1:0]      gnt_idx_r,   gnt_idx_s;
    logic               gnt_valid_r, gnt_valid_s;
    logic               timeout_r,   timeout_s;
    logic [IW-1:0]      cand_s;
    logic [IW-1:0]      win_idx_s;
    logic               win_found_s;
    logic               owner_rel_s;
    logic               wdog_s;
    logic [NUM_REQ-1:0] gnt_s;

    // Rotating search: first asserted request at or after the pointer, wrapping around.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = {IW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = ptr_r + IW'(k);
            if (!win_found_s && bus.req_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Owner release has priority over the watchdog, so a simultaneous done never reports a timeout.
    always_comb begin
        owner_rel_s = (!bus.req_i[gnt_idx_r]) || bus.done_i;
        wdog_s      = WDOG_EN && (hold_r == HOLD_LAST);
    end

    // Next-state and next-output logic of the IDLE/GRANT/GAP controller.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        hold_s      = hold_r;
        gnt_idx_s   = gnt_idx_r;
        gnt_valid_s = gnt_valid_r;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    gnt_idx_s   = win_idx_s;
                    gnt_valid_s = 1'b1;
                    hold_s      = 16'd0;
                    state_s     = ST_GRANT;
                end else begin
                    gnt_valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (owner_rel_s || wdog_s) begin
                    gnt_valid_s = 1'b0;
                    ptr_s       = gnt_idx_r + IW'(1);
                    timeout_s   = !owner_rel_s;
                    state_s     = ST_GAP;
                end else if (hold_r != 16'hFFFF) begin
                    hold_s = hold_r + 16'd1;
                end else begin
                    hold_s = hold_r;
                end
            end
            ST_GAP: begin
                gnt_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
            default: begin
                gnt_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IW{1'b0}};
            hold_r      <= 16'd0;
            gnt_idx_r   <= {IW{1'b0}};
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hold_r      <= hold_s;
            gnt_idx_r   <= gnt_idx_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
        end
    end

    // One-hot decode of the registered grant; all-zero whenever no grant is active.
    always_comb begin
        gnt_s = {NUM_REQ{1'b0}};
        if (gnt_valid_r) begin
            gnt_s[gnt_idx_r] = 1'b1;
        end else begin
            gnt_s = {NUM_REQ{1'b0}};
        end
    end

    assign bus.gnt_idx_o   = gnt_idx_r;
    assign bus.gnt_valid_o = gnt_valid_r;
    assign bus.gnt_o       = gnt_s;
    assign bus.timeout_o   = timeout_r;
endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: three instances (hold limits 16, 4, 1) share one stimulus stream
// and are compared every cycle against a behavioural arbitration model.
module tb_rr_grant_sched;
    localparam int N  = 4;
    localparam int NI = 3;

    logic         clk;
    logic         arst_n;
    logic [N-1:0] req;
    logic         done;
    bit           run_chk;
    int           vectors;
    int           miscompares;

    logic [1:0]   d_idx   [NI];
    logic         d_valid [NI];
    logic [N-1:0] d_gnt   [NI];
    logic         d_to    [NI];

    rr_grant_sched_if #(.NUM_REQ(N)) bus [NI] ();

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            assign bus[g].req_i  = req;
            assign bus[g].done_i = done;
            assign d_idx[g]      = bus[g].gnt_idx_o;
            assign d_valid[g]    = bus[g].gnt_valid_o;
            assign d_gnt[g]      = bus[g].gnt_o;
            assign d_to[g]       = bus[g].timeout_o;
            rr_grant_sched #(
                .NUM_REQ (N),
                .MAX_HOLD((g == 0) ? 16 : ((g == 1) ? 4 : 1))
            ) u_dut (
                .clk_i  (clk),
                .arst_ni(arst_n),
                .bus    (bus[g])
            );
        end
    endgenerate

    function automatic int lim(int i);
        case (i)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    // Model state: who owns the resource (-1 = nobody), how many edges the grant survived,
    // whether the turnaround cycle is pending, where priority starts, last index shown.
    typedef struct {
        int own;
        int held;
        int ptr;
        int last;
        bit cool;
        bit to;
    } mst_t;

    mst_t m [NI];

    function automatic mst_t nxt(mst_t s, logic [N-1:0] r, logic d, int l);
        mst_t n;
        n    = s;
        n.to = 1'b0;
        if (s.own >= 0) begin
            if (!r[s.own] || d) begin
                n.ptr = (s.own + 1) % N; n.own = -1; n.cool = 1'b1;
            end else if (l != 0 && s.held == l - 1) begin
                n.ptr = (s.own + 1) % N; n.own = -1; n.cool = 1'b1; n.to = 1'b1;
            end else begin
                n.held = s.held + 1;
            end
        end else if (s.cool) begin
            n.cool = 1'b0;
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (s.ptr + k) % N;
                if (n.own < 0 && r[c]) begin
                    n.own = c; n.last = c; n.held = 0;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NI; i++) m[i] <= '{own: -1, held: 0, ptr: 0, last: 0, cool: 1'b0, to: 1'b0};
        end else begin
            for (int i = 0; i < NI; i++) m[i] <= nxt(m[i], req, done, lim(i));
        end
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (arst_n && run_chk) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("valid[%0d]", i), 32'(d_valid[i]), 32'(m[i].own >= 0));
                chk($sformatf("idx[%0d]", i), 32'(d_idx[i]), 32'(m[i].last));
                chk($sformatf("gnt[%0d]", i), 32'(d_gnt[i]),
                    (m[i].own >= 0) ? (32'd1 << m[i].last) : 32'd0);
                chk($sformatf("timeout[%0d]", i), 32'(d_to[i]), 32'(m[i].to));
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int i, output int gaps);
        gaps = 0;
        while (d_valid[i] !== 1'b1 && gaps < 60) begin
            step();
            gaps++;
        end
        chk("wait_valid_bound", 32'(d_valid[i]), 32'd1);
    endtask

    logic [1:0] seq [5];
    int         g;
    int         cnt;

    initial begin
        vectors = 0; miscompares = 0; run_chk = 1'b0;
        seq[0] = 2'd3; seq[1] = 2'd0; seq[2] = 2'd1; seq[3] = 2'd2; seq[4] = 2'd3;
        arst_n = 1'b0; req = 4'b0000; done = 1'b0;
        #12;
        chk("rst_valid", 32'(d_valid[0]), 32'd0);
        chk("rst_idx", 32'(d_idx[0]), 32'd0);
        chk("rst_gnt", 32'(d_gnt[0]), 32'd0);
        chk("rst_timeout", 32'(d_to[0]), 32'd0);
        @(negedge clk);
        arst_n = 1'b1; run_chk = 1'b1;
        step();

        // Single requester, released by done
        req = 4'b0100;
        step();
        chk("t1_valid", 32'(d_valid[0]), 32'd1);
        chk("t1_idx", 32'(d_idx[0]), 32'd2);
        chk("t1_gnt", 32'(d_gnt[0]), 32'b0100);
        done = 1'b1; step(); done = 1'b0;
        chk("t1_release", 32'(d_valid[0]), 32'd0);
        chk("t1_idx_hold", 32'(d_idx[0]), 32'd2);

        // All requesting: rotation starts at the pointer left at 3
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_valid(0, g);
            chk("t2_seq_idx", 32'(d_idx[0]), 32'(seq[k]));
            chk("t2_gap", 32'(g), 32'd2);
            done = 1'b1; step(); done = 1'b0;
            chk("t2_release", 32'(d_valid[0]), 32'd0);
        end

        // Watchdog on the 16-cycle instance
        req = 4'b0010;
        wait_valid(0, g);
        chk("t3_idx", 32'(d_idx[0]), 32'd1);
        cnt = 1;
        while (d_valid[0] === 1'b1 && cnt < 40) begin
            step();
            if (d_valid[0] === 1'b1) cnt++;
        end
        chk("t3_hold_len", 32'(cnt), 32'd16);
        chk("t3_timeout_pulse", 32'(d_to[0]), 32'd1);
        step();
        chk("t3_timeout_clear", 32'(d_to[0]), 32'd0);
        wait_valid(0, g);
        chk("t3_regrant_idx", 32'(d_idx[0]), 32'd1);
        chk("t3_regrant_gap", 32'(g), 32'd1);
        done = 1'b1; step(); done = 1'b0;

        // Owner drops request, pointer wraps from 3 to 0
        req = 4'b1001;
        wait_valid(0, g);
        chk("t4_idx3", 32'(d_idx[0]), 32'd3);
        req = 4'b0001;
        step();
        chk("t4_release", 32'(d_valid[0]), 32'd0);
        chk("t4_no_timeout", 32'(d_to[0]), 32'd0);
        wait_valid(0, g);
        chk("t4_wrap_idx", 32'(d_idx[0]), 32'd0);
        req = 4'b0000;
        repeat (4) step();

        // done coincides with watchdog expiry on the 4-cycle instance
        req = 4'b0100;
        wait_valid(1, g);
        chk("t5_idx", 32'(d_idx[1]), 32'd2);
        repeat (3) begin
            step();
            chk("t5_held", 32'(d_valid[1]), 32'd1);
        end
        done = 1'b1; step(); done = 1'b0;
        chk("t5_release", 32'(d_valid[1]), 32'd0);
        chk("t5_no_timeout", 32'(d_to[1]), 32'd0);
        req = 4'b0000;
        repeat (3) step();

        // Randomised traffic, checked by the per-cycle compare process
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 7) == 0);
            step();
        end
        req = 4'b0000; done = 1'b0;
        repeat (3) step();

        // Asynchronous reset in the middle of a grant
        req = 4'b0010;
        wait_valid(0, g);
        chk("t6_idx", 32'(d_idx[0]), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(d_valid[0]), 32'd0);
        chk("t6_rst_gnt", 32'(d_gnt[0]), 32'd0);
        chk("t6_rst_idx", 32'(d_idx[0]), 32'd0);
        chk("t6_rst_timeout", 32'(d_to[0]), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        wait_valid(0, g);
        chk("t6_regrant_idx", 32'(d_idx[0]), 32'd1);
        chk("t6_regrant_gnt", 32'(d_gnt[0]), 32'b0010);
        chk("t6_regrant_lat", 32'(g), 32'd1);
        req = 4'b0000;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
